argon_regfile_sb: RTL



---
 rtl/argon_regfile_pkg.sv | 29 ++
 rtl/argon_scoreboard.sv | 36 +++
 rtl/argon_regfile_sb.sv | 93 +++++++++
 3 files changed

// File: rtl/argon_regfile_pkg.sv
// Shared types, fixed-register index helpers and default parameters
// for the Argon parametrised register file.
package argon_regfile_pkg;
  typedef enum logic [1:0] {
    SP_NONE = 2'b00,
    SP_PUSH = 2'b01,
    SP_POP  = 2'b10,
    SP_RSVD = 2'b11
  } sp_op_e;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_NUM_REGS   = 8;
  localparam int DEF_READ_PORTS = 2;
  localparam int DEF_FLAG_BITS  = 8;
  localparam int DEF_SP_STRIDE  = 2;
  localparam int DEF_SP_RESET   = 0;

  function automatic int rv_idx(input int n);
    return n - 3;
  endfunction

  function automatic int sp_idx(input int n);
    return n - 2;
  endfunction

  function automatic int f_idx(input int n);
    return n - 1;
  endfunction
endpackage

// File: rtl/argon_scoreboard.sv
// Per-register busy bits for in-flight results: reserve sets, writeback
// clears, flush clears all; r0 is never busy.
module argon_scoreboard
  import argon_regfile_pkg::*;
#(
  parameter  int NUM_REGS = DEF_NUM_REGS,
  localparam int IW       = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_valid,
  input  logic [IW-1:0]       wr_idx,
  input  logic                res_valid,
  input  logic [IW-1:0]       res_idx,
  input  logic                flush,
  output logic                res_ready,
  output logic [NUM_REGS-1:0] busy
);
  logic [NUM_REGS-1:0] busy_next;

  // A same-cycle write to the reserved register retires the old producer.
  assign res_ready = res_valid &
                     ((res_idx == '0) | ~busy[res_idx] | (wr_valid & (wr_idx == res_idx)));

  always_comb begin
    busy_next = flush ? '0 : busy;
    if (wr_valid) busy_next[wr_idx] = 1'b0;
    if (res_ready && res_idx != '0) busy_next[res_idx] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end
endmodule

// File: rtl/argon_regfile_sb.sv
// Register file with write forwarding, busy scoreboard, flags merge and
// a stack-pointer unit generating push/pop addresses.
module argon_regfile_sb
  import argon_regfile_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int NUM_REGS   = DEF_NUM_REGS,
  parameter  int READ_PORTS = DEF_READ_PORTS,
  parameter  int FLAG_BITS  = DEF_FLAG_BITS,
  parameter  int SP_STRIDE  = DEF_SP_STRIDE,
  parameter  int SP_RESET   = DEF_SP_RESET,
  localparam int IW         = $clog2(NUM_REGS)
) (
  input  logic                             i_Clk,
  input  logic                             i_Reset,
  input  logic [READ_PORTS*IW-1:0]         i_RdIdx,
  output logic [READ_PORTS*DATA_WIDTH-1:0] o_RdData,
  output logic [READ_PORTS-1:0]            o_RdBusy,
  input  logic                             i_WrValid,
  input  logic [IW-1:0]                    i_WrIdx,
  input  logic [DATA_WIDTH-1:0]            i_WrData,
  input  logic                             i_ResValid,
  input  logic [IW-1:0]                    i_ResIdx,
  output logic                             o_ResReady,
  input  logic                             i_FlagsValid,
  input  logic [FLAG_BITS-1:0]             i_Flags,
  input  logic [1:0]                       i_SpOp,
  output logic [DATA_WIDTH-1:0]            o_SpAddr,
  input  logic                             i_Flush
);
  localparam int SP_I = sp_idx(NUM_REGS);
  localparam int F_I  = f_idx(NUM_REGS);

  logic [NUM_REGS-1:1][DATA_WIDTH-1:0] regs;
  logic [NUM_REGS-1:0]                 busy;
  logic [DATA_WIDTH-1:0]               sp_cur, sp_next;
  logic                                sp_upd;

  argon_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
    .clk       (i_Clk),
    .rst       (i_Reset),
    .wr_valid  (i_WrValid),
    .wr_idx    (i_WrIdx),
    .res_valid (i_ResValid),
    .res_idx   (i_ResIdx),
    .flush     (i_Flush),
    .res_ready (o_ResReady),
    .busy      (busy)
  );

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [IW-1:0] idx;
    logic          fwd;
    assign idx = i_RdIdx[p*IW +: IW];
    assign fwd = i_WrValid && (i_WrIdx == idx) && (idx != '0);
    assign o_RdData[p*DATA_WIDTH +: DATA_WIDTH] =
      (idx == '0) ? '0 : (fwd ? i_WrData : regs[idx]);
    assign o_RdBusy[p] = !fwd && busy[idx];
  end

  assign sp_cur = regs[SP_I];

  always_comb begin
    sp_next  = sp_cur;
    o_SpAddr = sp_cur;
    sp_upd   = 1'b0;
    case (sp_op_e'(i_SpOp))
      SP_PUSH: begin
        sp_next  = sp_cur - DATA_WIDTH'(SP_STRIDE);
        o_SpAddr = sp_next;
        sp_upd   = 1'b1;
      end
      SP_POP: begin
        sp_next = sp_cur + DATA_WIDTH'(SP_STRIDE);
        sp_upd  = 1'b1;
      end
      default: ;
    endcase
  end

  // Later NBAs win: a general write to SP blocks the SP update, and the
  // flags overwrite only the low bits after a same-cycle write to F.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      regs       <= '0;
      regs[SP_I] <= DATA_WIDTH'(SP_RESET);
    end else begin
      if (i_WrValid && i_WrIdx != '0) regs[i_WrIdx] <= i_WrData;
      if (sp_upd && !(i_WrValid && i_WrIdx == IW'(SP_I))) regs[SP_I] <= sp_next;
      if (i_FlagsValid) regs[F_I][FLAG_BITS-1:0] <= i_Flags;
    end
  end
endmodule
